// File: rtl/gate_vector_driver.sv
// Pseudo-random stimulus driver for a 13-input/10-output gate model.
// Applies LFSR vectors, waits a settle delay, and compacts each response into a MISR.
module gate_vector_driver #(
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    num_vec,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [12:0]         seed,
    input  logic [9:0]          resp_in,
    output logic [12:0]         vec_out,
    output logic                busy,
    output logic                done,
    output logic [9:0]          signature,
    output logic [CNT_W-1:0]    vec_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SETTLE_W-1:0] WAIT_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [CNT_W-1:0]    num_lat;
    logic [SETTLE_W-1:0] settle_lat;
    logic [SETTLE_W-1:0] wait_cnt;
    logic [CNT_W-1:0]    cnt_inc;

    assign cnt_inc = vec_cnt + CNT_ONE;

    function automatic logic [12:0] lfsr_next(input logic [12:0] v);
        return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [9:0] misr_next(input logic [9:0] m, input logic [9:0] r);
        return {m[8:0], m[9] ^ m[6]} ^ r;
    endfunction

    // vec_out is the LFSR itself, so a vector stays put from APPLY through CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_out    <= '0;
            signature  <= '0;
            vec_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            num_lat    <= '0;
            settle_lat <= '0;
            wait_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        signature <= '0;
                        vec_cnt   <= '0;
                        if (num_vec != '0) begin
                            num_lat    <= num_vec;
                            settle_lat <= settle;
                            vec_out    <= (seed == 13'h0000) ? 13'h0001 : seed;
                            busy       <= 1'b1;
                            state      <= APPLY;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                APPLY: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_lat == '0) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= settle_lat;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wait_cnt <= WAIT_ONE) begin
                        wait_cnt <= '0;
                        state    <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_ONE;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        signature <= misr_next(signature, resp_in);
                        vec_cnt   <= cnt_inc;
                        vec_out   <= lfsr_next(vec_out);
                        if (cnt_inc == num_lat) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= APPLY;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_driver.sv
// Self-checking bench for gate_vector_driver: directed spot checks plus a randomized
// run compared every cycle against a cycle-position model of a vector run.
module tb_gate_vector_driver;

    localparam int CNT_W    = 16;
    localparam int SETTLE_W = 4;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [CNT_W-1:0]    num_vec;
    logic [SETTLE_W-1:0] settle;
    logic [12:0]         seed;
    logic [9:0]          resp_in;
    logic [12:0]         vec_out;
    logic                busy;
    logic                done;
    logic [9:0]          signature;
    logic [CNT_W-1:0]    vec_cnt;

    int checks = 0;
    int passes = 0;

    gate_vector_driver #(.CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_vec   (num_vec),
        .settle    (settle),
        .seed      (seed),
        .resp_in   (resp_in),
        .vec_out   (vec_out),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .vec_cnt   (vec_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] lfsr_step(input logic [12:0] v);
        return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [9:0] misr_step(input logic [9:0] m, input logic [9:0] r);
        return {m[8:0], m[9] ^ m[6]} ^ r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: a run is a sequence of (settle+2)-cycle vector slots; the
    // last cycle of each slot captures the response and moves to the next vector.
    logic [12:0]      m_vec    = '0;
    logic [9:0]       m_sig    = '0;
    logic [CNT_W-1:0] m_cnt    = '0;
    logic [CNT_W-1:0] m_n      = '0;
    logic             m_busy   = 1'b0;
    logic             m_done   = 1'b0;
    int unsigned      m_k      = 0;
    int unsigned      m_period = 2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vec  = '0;
            m_sig  = '0;
            m_cnt  = '0;
            m_n    = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 1'b0;
            end else begin
                if (m_k % m_period == m_period - 1) begin
                    m_sig = misr_step(m_sig, resp_in);
                    m_vec = lfsr_step(m_vec);
                    m_cnt = m_cnt + 1'b1;
                    if (m_cnt == m_n) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
                m_k++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            m_sig = '0;
            m_cnt = '0;
            if (num_vec == '0) begin
                m_done = 1'b1;
            end else begin
                m_n      = num_vec;
                m_period = int'(settle) + 2;
                m_k      = 0;
                m_vec    = (seed == 13'h0000) ? 13'h0001 : seed;
                m_busy   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("vec_out", 32'(vec_out), 32'(m_vec));
        checkOutput("signature", 32'(signature), 32'(m_sig));
        checkOutput("vec_cnt", 32'(vec_cnt), 32'(m_cnt));
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("done", 32'(done), 32'(m_done));
    end

    // Pulses start for one cycle; returns at the negedge of cycle 1 after the start edge.
    task automatic applyStimulus(input logic [CNT_W-1:0] n, input logic [SETTLE_W-1:0] s,
                                 input logic [12:0] sd, input logic [9:0] r);
        @(negedge clk);
        num_vec = n;
        settle  = s;
        seed    = sd;
        resp_in = r;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        num_vec = '0;
        settle  = '0;
        seed    = '0;
        resp_in = '0;
        @(negedge clk);
        checkOutput("reset_vec_out", 32'(vec_out), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        #2 rst_n = 1'b1;

        // Four vectors from seed 1, no settle, zero response
        applyStimulus(16'd4, 4'd0, 13'h0001, 10'h000);
        checkOutput("seq_v0", 32'(vec_out), 32'h0001);
        wait_cycles(2);
        checkOutput("seq_v1", 32'(vec_out), 32'h0003);
        wait_cycles(2);
        checkOutput("seq_v2", 32'(vec_out), 32'h0007);
        wait_cycles(2);
        checkOutput("seq_v3", 32'(vec_out), 32'h000E);
        wait_cycles(2);
        checkOutput("seq_done", 32'(done), 32'h1);
        checkOutput("seq_sig", 32'(signature), 32'h000);
        checkOutput("seq_cnt", 32'(vec_cnt), 32'd4);
        wait_cycles(2);

        // Single vector timing
        applyStimulus(16'd1, 4'd0, 13'h0001, 10'h000);
        checkOutput("one_busy_c1", 32'(busy), 32'h1);
        wait_cycles(1);
        checkOutput("one_done_c2", 32'(done), 32'h0);
        wait_cycles(1);
        checkOutput("one_done_c3", 32'(done), 32'h1);
        checkOutput("one_busy_c3", 32'(busy), 32'h0);
        wait_cycles(2);

        // Two vectors, settle 3, constant response 1
        applyStimulus(16'd2, 4'd3, 13'h0001, 10'h001);
        wait_cycles(9);
        checkOutput("settle_done_c10", 32'(done), 32'h0);
        wait_cycles(1);
        checkOutput("settle_done_c11", 32'(done), 32'h1);
        checkOutput("settle_sig", 32'(signature), 32'h003);
        checkOutput("settle_cnt", 32'(vec_cnt), 32'd2);
        wait_cycles(2);

        // Zero seed is replaced by 1
        applyStimulus(16'd1, 4'd0, 13'h0000, 10'h000);
        checkOutput("zero_seed_vec", 32'(vec_out), 32'h0001);
        wait_cycles(4);

        // Zero vector count goes straight to DONE
        applyStimulus(16'd0, 4'd0, 13'h0005, 10'h3FF);
        checkOutput("nv0_done", 32'(done), 32'h1);
        checkOutput("nv0_busy", 32'(busy), 32'h0);
        checkOutput("nv0_sig", 32'(signature), 32'h000);
        checkOutput("nv0_cnt", 32'(vec_cnt), 32'd0);
        wait_cycles(1);
        checkOutput("nv0_busy_c2", 32'(busy), 32'h0);
        wait_cycles(2);

        // Abort during the settle window of vector 2 of 5
        applyStimulus(16'd5, 4'd3, 13'h1ACE, 10'h2A5);
        wait_cycles(7);
        checkOutput("abort_busy_before", 32'(busy), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy_after", 32'(busy), 32'h0);
        checkOutput("abort_cnt", 32'(vec_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_no_done", 32'(done), 32'h0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a run
        applyStimulus(16'd5, 4'd2, 13'h0123, 10'h155);
        wait_cycles(6);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_vec_out", 32'(vec_out), 32'h0);
        checkOutput("arst_sig", 32'(signature), 32'h0);
        checkOutput("arst_cnt", 32'(vec_cnt), 32'h0);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("arst_no_done", 32'(done), 32'h0);
        end

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 24) == 0);
            num_vec = CNT_W'($urandom_range(0, 6));
            settle  = ($urandom_range(0, 3) == 0) ? SETTLE_W'($urandom_range(0, 15))
                                                  : SETTLE_W'($urandom_range(0, 2));
            seed    = ($urandom_range(0, 7) == 0) ? 13'h0000 : 13'($urandom);
            resp_in = 10'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        wait_cycles(2);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
